// File: rtl/sprite_blitter.sv
// -----------------------------------------------------------------------------
// sprite_blitter
//
// Write-side engine for a palette-index frame buffer. A start strobe copies a
// rectangular sprite from a synchronous sprite ROM into the frame-buffer write
// port at a given screen position, one pixel per clock. Transparent pixels are
// skipped and any pixel that lands off-screen is clipped.
//
// Ports:
//   Clk       - system clock, rising edge
//   Reset_n   - asynchronous active-low reset; aborts a blit in progress
//   start     - one-cycle command strobe, honoured only when idle
//   dst_x/y   - screen position of the sprite's top-left pixel
//   spr_w/h   - sprite size in pixels (0 in either => immediate done, no writes)
//   spr_base  - ROM address of sprite pixel (0,0), row-major, stride spr_w
//   spr_addr  - registered sprite ROM read address
//   spr_data  - ROM read data, one clock behind spr_addr
//   fb_we     - registered frame-buffer write enable
//   fb_addr   - frame-buffer write address, y*FB_W + x
//   fb_data   - palette index to write
//   busy      - high while a blit is in progress
//   done      - one-cycle pulse when a blit (or a zero-size command) completes
// -----------------------------------------------------------------------------
module sprite_blitter #(
   parameter int               FB_W        = 640,
   parameter int               FB_H        = 480,
   parameter int               PIX_W       = 4,
   parameter int               SPR_ADDR_W  = 12,
   parameter logic [PIX_W-1:0] TRANSPARENT = '0
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  start,
   input  logic [9:0]            dst_x,
   input  logic [9:0]            dst_y,
   input  logic [6:0]            spr_w,
   input  logic [6:0]            spr_h,
   input  logic [SPR_ADDR_W-1:0] spr_base,
   output logic [SPR_ADDR_W-1:0] spr_addr,
   input  logic [PIX_W-1:0]      spr_data,
   output logic                  fb_we,
   output logic [18:0]           fb_addr,
   output logic [PIX_W-1:0]      fb_data,
   output logic                  busy,
   output logic                  done
);

   localparam logic [10:0] C_FB_W = 11'(FB_W);
   localparam logic [10:0] C_FB_H = 11'(FB_H);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_DRAIN1 = 2'd2,
      S_DRAIN2 = 2'd3
   } state_t;

   // y*640 + x built from shifts; wraps modulo 2^19 exactly like a 19-bit sum
   function automatic logic [18:0] f_fb_addr(input logic [10:0] x, input logic [10:0] y);
      logic [18:0] y19;
      y19 = {8'd0, y};
      return (y19 << 9) + (y19 << 7) + {8'd0, x};
   endfunction

   function automatic logic f_on_screen(input logic [10:0] x, input logic [10:0] y);
      return (x < C_FB_W) && (y < C_FB_H);
   endfunction

   state_t                r_state;
   state_t                w_state_nxt;
   logic [6:0]            r_col;
   logic [6:0]            w_col_nxt;
   logic [6:0]            r_row;
   logic [6:0]            w_row_nxt;
   logic [SPR_ADDR_W-1:0] r_spr_addr;
   logic [SPR_ADDR_W-1:0] w_spr_addr_nxt;
   logic                  r_busy;
   logic                  w_busy_nxt;
   logic                  r_done;
   logic                  w_done_nxt;
   logic                  w_latch;

   logic [9:0]            r_dst_x;
   logic [9:0]            r_dst_y;
   logic [6:0]            r_spr_w;
   logic [6:0]            r_spr_h;

   logic                  w_last_col;
   logic                  w_last_row;

   logic                  r_vld_p0;
   logic [10:0]           r_x_p0;
   logic [10:0]           r_y_p0;

   logic                  r_fb_we;
   logic [18:0]           r_fb_addr;
   logic [PIX_W-1:0]      r_fb_data;

   assign w_last_col = (r_col == (r_spr_w - 7'd1));
   assign w_last_row = (r_row == (r_spr_h - 7'd1));

   // ---------------------------------------------------------------- control FSM
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state    <= S_IDLE;
         r_col      <= '0;
         r_row      <= '0;
         r_spr_addr <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_col      <= w_col_nxt;
         r_row      <= w_row_nxt;
         r_spr_addr <= w_spr_addr_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_col_nxt      = r_col;
      w_row_nxt      = r_row;
      w_spr_addr_nxt = r_spr_addr;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
      w_latch        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_latch = 1'b1;
               if ((spr_w == 7'd0) || (spr_h == 7'd0)) begin
                  // nothing to copy: acknowledge without ever going busy
                  w_done_nxt = 1'b1;
               end else begin
                  w_state_nxt    = S_RUN;
                  w_busy_nxt     = 1'b1;
                  w_spr_addr_nxt = spr_base;
                  w_col_nxt      = '0;
                  w_row_nxt      = '0;
               end
            end
         end
         S_RUN: begin
            // ROM storage is row-major with stride spr_w, so the address is a
            // plain linear walk with no row jumps
            w_spr_addr_nxt = r_spr_addr + 1'b1;
            if (w_last_col) begin
               w_col_nxt = '0;
               if (w_last_row) begin
                  w_state_nxt = S_DRAIN1;
               end else begin
                  w_row_nxt = r_row + 7'd1;
               end
            end else begin
               w_col_nxt = r_col + 7'd1;
            end
         end
         S_DRAIN1: begin
            w_state_nxt = S_DRAIN2;
         end
         S_DRAIN2: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // command parameters held for the duration of the blit
   always_ff @(posedge Clk) begin
      if (w_latch) begin
         r_dst_x <= dst_x;
         r_dst_y <= dst_y;
         r_spr_w <= spr_w;
         r_spr_h <= spr_h;
      end
   end

   // ---------------------------------------------------------------- stage p0
   // Destination of the pixel currently on spr_addr, captured on the same edge
   // the ROM samples that address, so it lines up with spr_data. 11-bit sums
   // cannot wrap (1023 + 126 < 2048).
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_vld_p0 <= 1'b0;
      end else begin
         r_vld_p0 <= (r_state == S_RUN);
      end
   end

   always_ff @(posedge Clk) begin
      r_x_p0 <= {1'b0, r_dst_x} + {4'd0, r_col};
      r_y_p0 <= {1'b0, r_dst_y} + {4'd0, r_row};
   end

   // ---------------------------------------------------------------- write stage
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_fb_we   <= 1'b0;
         r_fb_addr <= '0;
         r_fb_data <= '0;
      end else begin
         r_fb_we <= r_vld_p0 && (spr_data != TRANSPARENT) && f_on_screen(r_x_p0, r_y_p0);
         if (r_vld_p0) begin
            r_fb_addr <= f_fb_addr(r_x_p0, r_y_p0);
            r_fb_data <= spr_data;
         end
      end
   end

   assign spr_addr = r_spr_addr;
   assign fb_we    = r_fb_we;
   assign fb_addr  = r_fb_addr;
   assign fb_data  = r_fb_data;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_sprite_blitter.sv
// -----------------------------------------------------------------------------
// tb_sprite_blitter
//
// Bench for sprite_blitter: a behavioural sprite ROM, a frame-buffer write
// monitor checked against a scoreboard of expected writes, a table of blit
// commands, and hand sequences for zero size, busy rejection and mid-blit reset.
// -----------------------------------------------------------------------------
module tb_sprite_blitter;

   logic        Clk;
   logic        Reset_n;
   logic        start;
   logic [9:0]  dst_x;
   logic [9:0]  dst_y;
   logic [6:0]  spr_w;
   logic [6:0]  spr_h;
   logic [11:0] spr_base;
   logic [11:0] spr_addr;
   logic [3:0]  spr_data;
   logic        fb_we;
   logic [18:0] fb_addr;
   logic [3:0]  fb_data;
   logic        busy;
   logic        done;

   sprite_blitter dut (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .start    (start),
      .dst_x    (dst_x),
      .dst_y    (dst_y),
      .spr_w    (spr_w),
      .spr_h    (spr_h),
      .spr_base (spr_base),
      .spr_addr (spr_addr),
      .spr_data (spr_data),
      .fb_we    (fb_we),
      .fb_addr  (fb_addr),
      .fb_data  (fb_data),
      .busy     (busy),
      .done     (done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // synchronous sprite ROM
   logic [3:0] rom [0:4095];
   always @(posedge Clk) spr_data <= rom[spr_addr];

   int e = 0;
   always @(posedge Clk) e <= e + 1;

   typedef struct {
      int ed;
      int addr;
      int data;
   } wr_t;

   typedef struct {
      int x;
      int y;
      int w;
      int h;
      int b;
      int exp_wr;
      int first;
      int last;
   } vec_t;

   wr_t  sb[$];
   vec_t vt[7];

   int n_checks = 0;
   int n_fail   = 0;
   int wr_cnt, done_cnt, done_edge, first_addr, last_addr;
   bit mon_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // write / done monitor, sampled away from the active edge
   always @(negedge Clk) begin
      wr_t w;
      if (mon_en) begin
         if (fb_we !== 1'b0) begin
            wr_cnt++;
            if (wr_cnt == 1) first_addr = int'(fb_addr);
            last_addr = int'(fb_addr);
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write addr=%0d edge=%0d required=no write", fb_addr, e);
            end else begin
               w = sb.pop_front();
               chk("wr_edge", e, w.ed);
               chk("wr_addr", {13'd0, fb_addr}, w.addr);
               chk("wr_data", {28'd0, fb_data}, w.data);
            end
         end
         if (done === 1'b1) begin
            done_cnt++;
            done_edge = e;
         end
      end
   end

   task automatic clear_mon();
      wr_cnt     = 0;
      done_cnt   = 0;
      done_edge  = -1;
      first_addr = -1;
      last_addr  = -1;
      sb.delete();
   endtask

   // start is sampled at edge k; returns just after edge k
   task automatic start_blit(input int x, input int y, input int w, input int h,
                             input int b, output int k);
      @(posedge Clk);
      #1;
      dst_x    = 10'(x);
      dst_y    = 10'(y);
      spr_w    = 7'(w);
      spr_h    = 7'(h);
      spr_base = 12'(b);
      start    = 1'b1;
      k        = e + 1;
      @(posedge Clk);
      #1;
      start = 1'b0;
   endtask

   // reference model: pixel n's write is visible after edge k+n+2
   task automatic push_model(input int k, input int x, input int y, input int w,
                             input int h, input int b, input int nmax, output int cnt);
      cnt = 0;
      for (int n = 0; n < w * h && n < nmax; n++) begin
         int px, py, d;
         px = x + (n % w);
         py = y + (n / w);
         d  = int'(rom[(b + n) % 4096]);
         if (d != 0 && px < 640 && py < 480) begin
            sb.push_back('{ed: k + n + 2, addr: py * 640 + px, data: d});
            cnt++;
         end
      end
   endtask

   task automatic finish_blit(input string nm, input int k, input int n, input int exp_wr,
                              input int first, input int last, input int model_cnt);
      int cnt;
      cnt = 0;
      while (done_cnt == 0 && cnt < n + 20) begin
         @(posedge Clk);
         cnt++;
      end
      repeat (3) @(posedge Clk);
      #1;
      chk({nm, "_done_cnt"}, done_cnt, 1);
      chk({nm, "_done_edge"}, done_edge, k + n + 2);
      chk({nm, "_wr_cnt"}, wr_cnt, (exp_wr >= 0) ? exp_wr : model_cnt);
      chk({nm, "_sb_left"}, sb.size(), 0);
      chk({nm, "_busy_end"}, {31'd0, busy}, 0);
      if (exp_wr > 0) begin
         chk({nm, "_first_addr"}, first_addr, first);
         chk({nm, "_last_addr"}, last_addr, last);
      end
      sb.delete();
   endtask

   initial begin
      int k, mc;

      for (int i = 0; i < 4096; i++) rom[i] = 4'h0;
      for (int i = 0; i < 8; i++) rom[i] = 4'h5;
      rom[16] = 4'h3; rom[17] = 4'h0; rom[18] = 4'h7;
      for (int i = 32; i < 40; i++) rom[i] = 4'h1;
      for (int i = 0; i < 16; i++) rom[64 + i] = 4'((i % 15) + 1);
      for (int i = 128; i < 256; i++) rom[i] = 4'($urandom_range(0, 15));
      for (int i = 256; i < 512; i++) rom[i] = 4'h9;

      //            x     y     w    h    base exp_wr first   last
      vt[0] = '{   0,    0,    4,   2,    0,   8,     0,      643};
      vt[1] = '{  10,   20,    3,   1,   16,   2, 12810,    12812};
      vt[2] = '{ 638,  479,    4,   2,   32,   2, 307198, 307199};
      vt[3] = '{ 100,  100,    4,   4,   64,  16, 64100,   66023};
      vt[4] = '{   5,  470,   10,   7,  128,  -1,    -1,      -1};
      vt[5] = '{1020, 1022,   10,   2,   64,   0,    -1,      -1};
      vt[6] = '{ 600,    0,  127,   1,  256,  40,   600,      639};

      start = 1'b0; dst_x = '0; dst_y = '0; spr_w = '0; spr_h = '0; spr_base = '0;
      Reset_n = 1'b1;
      clear_mon();
      #2 Reset_n = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      chk("reset_busy", {31'd0, busy}, 0);
      chk("reset_done", {31'd0, done}, 0);
      chk("reset_fb_we", {31'd0, fb_we}, 0);
      chk("reset_fb_addr", {13'd0, fb_addr}, 0);
      chk("reset_fb_data", {28'd0, fb_data}, 0);
      chk("reset_spr_addr", {20'd0, spr_addr}, 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      mon_en  = 1'b1;

      // zero-size command
      clear_mon();
      start_blit(7, 9, 0, 5, 100, k);
      @(negedge Clk);
      chk("zs_done", {31'd0, done}, 1);
      chk("zs_busy", {31'd0, busy}, 0);
      chk("zs_spr_addr", {20'd0, spr_addr}, 0);
      @(negedge Clk);
      chk("zs_done_pulse", {31'd0, done}, 0);
      chk("zs_busy2", {31'd0, busy}, 0);
      repeat (3) @(negedge Clk);
      chk("zs_done_cnt", done_cnt, 1);
      chk("zs_done_edge", done_edge, k);
      chk("zs_wr_cnt", wr_cnt, 0);
      chk("zs_spr_addr2", {20'd0, spr_addr}, 0);

      // table-driven blits
      for (int i = 0; i < 7; i++) begin
         clear_mon();
         start_blit(vt[i].x, vt[i].y, vt[i].w, vt[i].h, vt[i].b, k);
         push_model(k, vt[i].x, vt[i].y, vt[i].w, vt[i].h, vt[i].b, 1 << 20, mc);
         @(negedge Clk);
         chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 1);
         finish_blit($sformatf("vec%0d", i), k, vt[i].w * vt[i].h, vt[i].exp_wr,
                     vt[i].first, vt[i].last, mc);
      end

      // start while busy is ignored
      clear_mon();
      start_blit(100, 100, 4, 4, 64, k);
      push_model(k, 100, 100, 4, 4, 64, 1 << 20, mc);
      repeat (2) @(posedge Clk);
      #1;
      dst_x = 10'd200; dst_y = 10'd200; spr_w = 7'd2; spr_h = 7'd2; spr_base = 12'd0;
      start = 1'b1;
      @(posedge Clk);
      #1;
      start = 1'b0;
      chk("rej_busy", {31'd0, busy}, 1);
      finish_blit("rej", k, 16, 16, 64100, 66023, mc);

      // reset mid-blit at edge k+5: pixels 0..2 are already written
      clear_mon();
      start_blit(50, 60, 4, 4, 64, k);
      push_model(k, 50, 60, 4, 4, 64, 3, mc);
      repeat (5) @(posedge Clk);
      Reset_n = 1'b0;
      #1;
      chk("rst_fb_we", {31'd0, fb_we}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_fb_addr", {13'd0, fb_addr}, 0);
      chk("rst_fb_data", {28'd0, fb_data}, 0);
      chk("rst_spr_addr", {20'd0, spr_addr}, 0);
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      repeat (12) @(negedge Clk);
      chk("rst_done_cnt", done_cnt, 0);
      chk("rst_wr_cnt", wr_cnt, 3);
      chk("rst_sb_left", sb.size(), 0);

      // full blit after reset release
      clear_mon();
      start_blit(vt[3].x, vt[3].y, vt[3].w, vt[3].h, vt[3].b, k);
      push_model(k, vt[3].x, vt[3].y, vt[3].w, vt[3].h, vt[3].b, 1 << 20, mc);
      finish_blit("post_rst", k, 16, vt[3].exp_wr, vt[3].first, vt[3].last, mc);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
